// File: rtl/cmult_share_arb.sv
// Round-robin share of one combinational complex multiplier; optional CMULT_ARB_STATS_EN adds grant/stall counters.
// Latency: gnt[i] in cycle t -> rsp_valid with rsp_id=i in cycle t+1; one result per cycle sustained.
// Backpressure: a held result with rsp_ready low blocks all grants; drain and refill share one edge.
module cmult_share_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       mult_in,
    input  logic [DW-1:0]       mult_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IW-1:0]       rsp_id,
    output logic [DW-1:0]       rsp_data
`ifdef CMULT_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] stat_grants,
    output logic [15:0]         stat_stall
`endif
);

    logic [IW-1:0] last;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          can_issue;

    // (base + k) mod N_REQ without relying on N_REQ being a power of two
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    assign can_issue = !rsp_valid || rsp_ready;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        mult_in = '0;
        if (rst_n && can_issue) begin
            for (int k = 1; k <= N_REQ; k++) begin
                if (!gnt_any && req[rr_idx(last, k)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = rr_idx(last, k);
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
            mult_in      = req_data[int'(gnt_idx)*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            last      <= IW'(N_REQ - 1);
        end else if (gnt_any) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mult_out;
            rsp_id    <= gnt_idx;
            last      <= gnt_idx;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef CMULT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i] && stat_grants[i*16 +: 16] != 16'hFFFF)
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
            end
            // stall: somebody is asking but the output register refuses to take a result
            if ((|req) && !gnt_any && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule
